alu_exec_unit: RTL

- Execute-stage ALU that consumes the 4-bit ALUctrl code from the ALU control decoder, plus operands, a shift amount and a destination-register tag.
- Arithmetic and logic ops complete in one cycle. SLL/SRL/SRA run on an iterative 1-bit-per-cycle shifter.
- Valid/ready handshakes on both sides. Sits between the ID/EX register and the EX/MEM register.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_iter_shifter.sv | 70 +++++++
 rtl/alu_exec_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALUctrl encodings, default widths and execute-stage
//               state encoding for the ALU control decoder and exec unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default datapath widths
    localparam int c_DATA_W  = 32;
    localparam int c_SHAMT_W = 5;
    localparam int c_TAG_W   = 5;

    // ALUctrl codes (single definition shared with the control decoder)
    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_AND = 4'b0010;
    localparam logic [3:0] c_ALU_OR  = 4'b0011;
    localparam logic [3:0] c_ALU_XOR = 4'b0101;
    localparam logic [3:0] c_ALU_NOR = 4'b0110;
    localparam logic [3:0] c_ALU_SLL = 4'b0111;
    localparam logic [3:0] c_ALU_SRL = 4'b1000;
    localparam logic [3:0] c_ALU_SRA = 4'b1001;
    localparam logic [3:0] c_ALU_SLT = 4'b1100;

    // Execute-unit control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // True for the three codes handled by the iterative shifter
    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == c_ALU_SLL) || (code == c_ALU_SRL) || (code == c_ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_shifter
// Description : Iterative 1-bit-per-cycle shifter. Load captures the operand,
//               shift amount and direction; each step moves one bit and
//               decrements the counter. o_done is high whenever the counter
//               is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_shifter
    import alu_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int SHAMT_W = c_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_left,
    input  logic               i_arith,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_done
);

    logic [DATA_W-1:0]  r_data;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;
    logic               r_arith;
    logic [DATA_W-1:0]  w_shifted;
    logic               w_fill;

    // Fill bit for right shifts: sign bit for arithmetic, zero for logical
    assign w_fill = r_arith & r_data[DATA_W-1];

    // One-bit shift of the current register contents
    always_comb begin
        w_shifted = r_data;
        if (r_left) begin
            w_shifted = {r_data[DATA_W-2:0], 1'b0};
        end else begin
            w_shifted = {w_fill, r_data[DATA_W-1:1]};
        end
    end

    // Shift register and count-down counter; stepping stops at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_cnt   <= i_shamt;
            r_left  <= i_left;
            r_arith <= i_arith;
        end else if (i_step && (r_cnt != '0)) begin
            r_data  <= w_shifted;
            r_cnt   <= r_cnt - {{(SHAMT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_data = r_data;
    assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with valid/ready handshakes. Arithmetic and
//               logic ops finish in one cycle; SLL/SRL/SRA with a non-zero
//               shift amount use the iterative shifter (n+1 cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int SHAMT_W = c_SHAMT_W,
    parameter int TAG_W   = c_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic [TAG_W-1:0]   tag_out,
    output logic               zero,
    output logic               ovf,
    output logic               illegal
);

    alu_state_e        r_state;
    alu_state_e        w_state_next;

    logic [DATA_W-1:0] r_result;
    logic [TAG_W-1:0]  r_tag;
    logic              r_zero;
    logic              r_ovf;
    logic              r_illegal;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_shift;
    logic              w_start_shift;
    logic              w_capture_alu;
    logic              w_capture_shift;
    logic              w_sh_step;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_slt;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_ovf;
    logic              w_alu_illegal;

    logic [DATA_W-1:0] w_sh_data;
    logic              w_sh_done;

    // Handshake: a pending result being consumed frees the unit this cycle
    assign w_in_ready    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept      = in_valid && w_in_ready;
    assign w_is_shift    = is_shift_op(alu_ctrl);
    assign w_start_shift = w_accept && w_is_shift && (shamt != '0);

    assign w_sum  = op_a + op_b;
    assign w_diff = op_a - op_b;
    assign w_slt  = $signed(op_a) < $signed(op_b);

    // Single-cycle datapath; shift codes here only cover the shamt==0 case
    always_comb begin
        w_alu_result  = '0;
        w_alu_ovf     = 1'b0;
        w_alu_illegal = 1'b0;
        case (alu_ctrl)
            c_ALU_ADD: begin
                w_alu_result = w_sum;
                w_alu_ovf    = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                               (w_sum[DATA_W-1] != op_a[DATA_W-1]);
            end
            c_ALU_SUB: begin
                w_alu_result = w_diff;
                w_alu_ovf    = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                               (w_diff[DATA_W-1] != op_a[DATA_W-1]);
            end
            c_ALU_AND: w_alu_result = op_a & op_b;
            c_ALU_OR:  w_alu_result = op_a | op_b;
            c_ALU_XOR: w_alu_result = op_a ^ op_b;
            c_ALU_NOR: w_alu_result = ~(op_a | op_b);
            c_ALU_SLT: w_alu_result = {{(DATA_W-1){1'b0}}, w_slt};
            c_ALU_SLL, c_ALU_SRL, c_ALU_SRA: w_alu_result = op_b;
            default:   w_alu_illegal = 1'b1;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_state_next    = r_state;
        w_capture_alu   = 1'b0;
        w_capture_shift = 1'b0;
        w_sh_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next  = w_start_shift ? ST_SHIFT : ST_DONE;
                    w_capture_alu = !w_start_shift;
                end
            end
            ST_SHIFT: begin
                w_sh_step = 1'b1;
                if (w_sh_done) begin
                    w_state_next    = ST_DONE;
                    w_capture_shift = 1'b1;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_next  = w_start_shift ? ST_SHIFT : ST_DONE;
                    w_capture_alu = !w_start_shift;
                end else if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output registers; untouched while a result waits for out_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_tag     <= '0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag <= tag_in;
            end
            if (w_capture_alu) begin
                r_result  <= w_alu_result;
                r_zero    <= (w_alu_result == '0);
                r_ovf     <= w_alu_ovf;
                r_illegal <= w_alu_illegal;
            end else if (w_capture_shift) begin
                r_result  <= w_sh_data;
                r_zero    <= (w_sh_data == '0);
                r_ovf     <= 1'b0;
                r_illegal <= 1'b0;
            end
        end
    end

    alu_iter_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_start_shift),
        .i_step  (w_sh_step),
        .i_left  (alu_ctrl == c_ALU_SLL),
        .i_arith (alu_ctrl == c_ALU_SRA),
        .i_data  (op_b),
        .i_shamt (shamt),
        .o_data  (w_sh_data),
        .o_done  (w_sh_done)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign tag_out   = r_tag;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire
